// File: rtl/hb_pkg.sv
// rtl/hb_pkg.sv - shared widths, coefficients and FSM states for the half-band interpolator
package hb_pkg;

  localparam int DW    = 35;
  localparam int NTAP  = 38;
  localparam int NCOEF = 19;
  localparam int PW    = 36;
  localparam int CW    = 30;
  localparam int ACCW  = 66;
  localparam int SHIFT = 29;
  localparam int CTR   = 18;

  // bit k set means coefficient pair k is subtracted (odd k)
  localparam logic [NCOEF-1:0] S_NEG = 19'h2AAAA;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PH_A = 2'd1,
    ST_PH_B = 2'd2
  } state_e;

  function automatic logic [CW-1:0] coef(input int k);
    case (k)
      0:       coef = 30'd3870;
      1:       coef = 30'd16305;
      2:       coef = 30'd48553;
      3:       coef = 30'd119259;
      4:       coef = 30'd257820;
      5:       coef = 30'd507429;
      6:       coef = 30'd928131;
      7:       coef = 30'd1599799;
      8:       coef = 30'd2625321;
      9:       coef = 30'd4135001;
      10:      coef = 30'd6294535;
      11:      coef = 30'd9321690;
      12:      coef = 30'd13522985;
      13:      coef = 30'd19377524;
      14:      coef = 30'd27742080;
      15:      coef = 30'd40418827;
      16:      coef = 30'd62096704;
      17:      coef = 30'd110065333;
      18:      coef = 30'd340477051;
      default: coef = '0;
    endcase
  endfunction

endpackage

// File: rtl/hb2_interp_mac.sv
// rtl/hb2_interp_mac.sv - combinational folded MAC for the filtered phase
// Rounds half-up at bit SHIFT-1 and clamps to the DW-bit signed range.
module hb2_interp_mac
  import hb_pkg::*;
(
  input  logic [NTAP*DW-1:0] taps_i,
  output logic [DW-1:0]      y_o,
  output logic               sat_o
);

  localparam logic signed [ACCW-1:0] RND  = ACCW'(1) <<< (SHIFT - 1);
  localparam logic signed [ACCW-1:0] YMAX = (ACCW'(1) <<< (DW - 1)) - ACCW'(1);
  localparam logic signed [ACCW-1:0] YMIN = -(ACCW'(1) <<< (DW - 1));

  logic        [DW-1:0]   pa;
  logic        [DW-1:0]   pb;
  logic        [PW-1:0]   p;
  logic        [ACCW-1:0] prod;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] rnd;
  logic signed [ACCW-1:0] shifted;

  always_comb begin
    pa   = '0;
    pb   = '0;
    p    = '0;
    prod = '0;
    acc  = '0;
    for (int k = 0; k < NCOEF; k++) begin
      pa   = taps_i[k*DW +: DW];
      pb   = taps_i[(NTAP-1-k)*DW +: DW];
      p    = {pa[DW-1], pa} + {pb[DW-1], pb};
      prod = {{(ACCW-PW){p[PW-1]}}, p} * {{(ACCW-CW){1'b0}}, coef(k)};
      if (S_NEG[k]) acc = acc - $signed(prod);
      else          acc = acc + $signed(prod);
    end
    rnd     = acc + RND;
    shifted = rnd >>> SHIFT;
    if (shifted > YMAX) begin
      y_o   = YMAX[DW-1:0];
      sat_o = 1'b1;
    end else if (shifted < YMIN) begin
      y_o   = YMIN[DW-1:0];
      sat_o = 1'b1;
    end else begin
      y_o   = shifted[DW-1:0];
      sat_o = 1'b0;
    end
  end

endmodule

// File: rtl/hb2_interp.sv
// rtl/hb2_interp.sv - half-band interpolate-by-2 top: delay line, phase FSM, output registers
// Each accepted input yields the filtered mid-point sample, then the centre tap.
module hb2_interp
  import hb_pkg::*;
(
  input  logic          clk,
  input  logic          rstn,
  input  logic          clk_vld_in,
  input  logic [DW-1:0] dat_in,
  output logic          clk_vld_out,
  output logic [DW-1:0] dat_out,
  output logic          sat_flag,
  output logic          ovr_err
);

  state_e               state_q;
  logic [NTAP*DW-1:0]   taps_q;
  logic [NTAP*DW-1:0]   taps_d;
  logic [DW-1:0]        dat_out_q;
  logic                 vld_q;
  logic                 sat_q;
  logic                 ovr_q;
  logic                 accept;
  logic [DW-1:0]        mac_y;
  logic                 mac_sat;

  // PH_A is the only busy cycle; a strobe there would corrupt the MAC operands
  assign accept = clk_vld_in && (state_q != ST_PH_A);
  assign taps_d = accept ? {taps_q[(NTAP-1)*DW-1:0], dat_in} : taps_q;

  hb2_interp_mac u_mac (
    .taps_i (taps_q),
    .y_o    (mac_y),
    .sat_o  (mac_sat)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      taps_q    <= '0;
      dat_out_q <= '0;
      vld_q     <= 1'b0;
      sat_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      taps_q <= taps_d;
      ovr_q  <= clk_vld_in && (state_q == ST_PH_A);
      vld_q  <= 1'b0;
      sat_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (clk_vld_in) state_q <= ST_PH_A;
        end
        ST_PH_A: begin
          state_q   <= ST_PH_B;
          dat_out_q <= mac_y;
          sat_q     <= mac_sat;
          vld_q     <= 1'b1;
        end
        ST_PH_B: begin
          state_q   <= clk_vld_in ? ST_PH_A : ST_IDLE;
          dat_out_q <= taps_q[CTR*DW +: DW];
          vld_q     <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign clk_vld_out = vld_q;
  assign dat_out     = dat_out_q;
  assign sat_flag    = sat_q;
  assign ovr_err     = ovr_q;

endmodule
